// File: rtl/kem_seed_collector.sv
// Collects NUM_WORDS PRNG words per run pulse into seed_o, one request in flight at a time.
// A WAIT timer per word aborts a stalled PRNG with err_o; clear_i zeroizes and aborts from any state.
module kem_seed_collector #(
    parameter int DATA_W      = 256,
    parameter int NUM_WORDS   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          run_i,
    input  logic                          clear_i,
    output logic                          prng_req_o,
    input  logic                          prng_vld_i,
    input  logic [DATA_W-1:0]             prng_data_i,
    output logic [NUM_WORDS*DATA_W-1:0]   seed_o,
    output logic                          seed_valid_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);
    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                        r_state;
    logic [CNT_W-1:0]              r_word_cnt;
    logic [TMR_W-1:0]              r_timer;
    logic [NUM_WORDS*DATA_W-1:0]   r_seed;
    logic                          r_req;
    logic                          r_done;
    logic                          r_busy;
    logic                          r_valid;
    logic                          r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_timer    <= '0;
            r_seed     <= '0;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else if (clear_i) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_seed     <= '0;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // req and done are single-cycle pulses: only the entering transition raises them
            r_req  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run_i) begin
                        r_state    <= S_REQ;
                        r_word_cnt <= '0;
                        r_valid    <= 1'b0;
                        r_err      <= 1'b0;
                        r_req      <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (prng_vld_i) begin
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            if (r_word_cnt == CNT_W'(k)) begin
                                r_seed[k*DATA_W +: DATA_W] <= prng_data_i;
                            end
                        end
                        if (r_word_cnt == LAST_WORD) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                            r_state    <= S_REQ;
                            r_req      <= 1'b1;
                        end
                    end else if (r_timer == LAST_TICK) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    r_valid <= !r_err;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign prng_req_o   = r_req;
    assign done_o       = r_done;
    assign busy_o       = r_busy;
    assign seed_valid_o = r_valid;
    assign err_o        = r_err;
    assign seed_o       = r_seed;
endmodule

// File: tb/tb_kem_seed_collector.sv
// Bench for kem_seed_collector: cycle-indexed run history compared against timing formulas.
module tb_kem_seed_collector;
    localparam int DW = 64, NW = 2, TO = 4, HMAX = 64;

    logic              clk_i, rst_i, run_i, clear_i, prng_req_o, prng_vld_i;
    logic [DW-1:0]     prng_data_i;
    logic [NW*DW-1:0]  seed_o;
    logic              seed_valid_o, busy_o, done_o, err_o;

    kem_seed_collector #(.DATA_W(DW), .NUM_WORDS(NW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .clear_i(clear_i),
        .prng_req_o(prng_req_o), .prng_vld_i(prng_vld_i), .prng_data_i(prng_data_i),
        .seed_o(seed_o), .seed_valid_o(seed_valid_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0, failures = 0;

    // run knobs and recorded history, indexed by cycle relative to the run pulse
    int lat, resp_limit, rerun_cyc, clear_cyc, rst_cyc;
    logic spur_at [HMAX];
    logic [DW-1:0] rsp_words [$];
    logic [NW*DW-1:0] seed_h [HMAX];
    logic req_h [HMAX], done_h [HMAX], busy_h [HMAX], valid_h [HMAX], err_h [HMAX];
    logic rst_zero_ok;

    task automatic knobs_default();
        lat = 1; resp_limit = NW; rerun_cyc = -1; clear_cyc = -1; rst_cyc = -1;
        for (int i = 0; i < HMAX; i++) spur_at[i] = 1'b0;
        rsp_words.delete();
        rst_zero_ok = 1'b0;
    endtask

    // Drives one run and plays the PRNG: answers requests after lat cycles with queued words.
    task automatic sim_run(input int ncyc);
        int due [$];
        int n_ans;
        int cyc;
        n_ans = 0;
        cyc = 0;
        run_i = 1'b1;
        clear_i = (clear_cyc == 0);
        prng_vld_i = spur_at[0];
        prng_data_i = {$urandom, $urandom};
        while (cyc < ncyc) begin
            @(posedge clk_i); #1;
            cyc++;
            seed_h[cyc] = seed_o; req_h[cyc] = prng_req_o; done_h[cyc] = done_o;
            busy_h[cyc] = busy_o; valid_h[cyc] = seed_valid_o; err_h[cyc] = err_o;
            if (prng_req_o && n_ans < resp_limit) begin
                due.push_back(cyc + lat);
                n_ans++;
            end
            if (cyc == rst_cyc) begin
                rst_i = 1'b1;
                #1;
                rst_zero_ok = (seed_o == '0) && !prng_req_o && !done_o && !busy_o
                              && !seed_valid_o && !err_o;
                rst_i = 1'b0;
            end
            run_i = (cyc == rerun_cyc);
            clear_i = (cyc == clear_cyc);
            prng_vld_i = spur_at[cyc];
            prng_data_i = {$urandom, $urandom};
            if (due.size() > 0 && due[0] == cyc) begin
                void'(due.pop_front());
                prng_vld_i = 1'b1;
                prng_data_i = rsp_words.pop_front();
            end
        end
        run_i = 1'b0; clear_i = 1'b0; prng_vld_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; run_i = 0; clear_i = 0; prng_vld_i = 0; prng_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (seed_o !== '0) begin failures++; $display("FAIL reset_seed got=%0h exp=0", seed_o); end
        checks++; if (prng_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", prng_req_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (seed_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", seed_valid_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_nominal();
        int nreq;
        knobs_default();
        rsp_words.push_back({(DW/8){8'hAA}});
        rsp_words.push_back({(DW/8){8'h55}});
        sim_run(8);
        nreq = 0;
        for (int c = 1; c <= 8; c++) nreq += int'(req_h[c]);
        checks++; if (req_h[1] !== 1'b1) begin failures++; $display("FAIL nom_req1 got=%b exp=1", req_h[1]); end
        checks++; if (req_h[3] !== 1'b1) begin failures++; $display("FAIL nom_req3 got=%b exp=1", req_h[3]); end
        checks++; if (nreq != 2) begin failures++; $display("FAIL nom_req_count got=%0d exp=2", nreq); end
        checks++; if (done_h[5] !== 1'b1) begin failures++; $display("FAIL nom_done5 got=%b exp=1", done_h[5]); end
        checks++; if (valid_h[5] !== 1'b0) begin failures++; $display("FAIL nom_valid5 got=%b exp=0", valid_h[5]); end
        checks++; if (valid_h[6] !== 1'b1) begin failures++; $display("FAIL nom_valid6 got=%b exp=1", valid_h[6]); end
        checks++; if (seed_h[8] !== {{(DW/8){8'h55}}, {(DW/8){8'hAA}}})
            begin failures++; $display("FAIL nom_seed got=%0h", seed_h[8]); end
        checks++; if (err_h[8] !== 1'b0) begin failures++; $display("FAIL nom_err got=%b exp=0", err_h[8]); end
        checks++; if (busy_h[6] !== 1'b0) begin failures++; $display("FAIL nom_busy6 got=%b exp=0", busy_h[6]); end
    endtask

    task automatic test_timeout();
        int nreq, ndone;
        knobs_default();
        resp_limit = 0;
        sim_run(10);
        nreq = 0; ndone = 0;
        for (int c = 1; c <= 10; c++) begin nreq += int'(req_h[c]); ndone += int'(done_h[c]); end
        checks++; if (nreq != 1) begin failures++; $display("FAIL to_req_count got=%0d exp=1", nreq); end
        checks++; if (done_h[1 + TO + 1] !== 1'b1) begin failures++; $display("FAIL to_done_cycle got=%b exp=1", done_h[1 + TO + 1]); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL to_done_count got=%0d exp=1", ndone); end
        checks++; if (err_h[8] !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err_h[8]); end
        checks++; if (valid_h[8] !== 1'b0) begin failures++; $display("FAIL to_valid got=%b exp=0", valid_h[8]); end
    endtask

    // Random latencies and random number of answered words; timeline from the run formulas.
    task automatic test_random();
        int L, A, d, n;
        logic [DW-1:0] w [NW];
        logic e_req, e_done, e_busy, e_valid, e_err;
        for (int it = 0; it < 8; it++) begin
            knobs_default();
            L = $urandom_range(1, TO);
            A = (it % 3 == 2) ? $urandom_range(0, NW - 1) : NW;
            lat = L; resp_limit = A;
            for (int k = 0; k < NW; k++) begin w[k] = {$urandom, $urandom}; rsp_words.push_back(w[k]); end
            d = (A == NW) ? 1 + NW * (L + 1) : 1 + A * (L + 1) + TO + 1;
            n = d + 3;
            sim_run(n);
            for (int c = 1; c <= n; c++) begin
                e_req = 1'b0;
                for (int k = 0; k < NW && k <= A; k++) if (c == 1 + k * (L + 1)) e_req = 1'b1;
                e_done = (c == d); e_busy = (c <= d);
                e_valid = (A == NW) && (c > d); e_err = (A < NW) && (c >= d);
                checks++; if (req_h[c] !== e_req) begin failures++; $display("FAIL rnd_req it=%0d c=%0d got=%b exp=%b", it, c, req_h[c], e_req); end
                checks++; if (done_h[c] !== e_done) begin failures++; $display("FAIL rnd_done it=%0d c=%0d got=%b exp=%b", it, c, done_h[c], e_done); end
                checks++; if (busy_h[c] !== e_busy) begin failures++; $display("FAIL rnd_busy it=%0d c=%0d got=%b exp=%b", it, c, busy_h[c], e_busy); end
                checks++; if (valid_h[c] !== e_valid) begin failures++; $display("FAIL rnd_valid it=%0d c=%0d got=%b exp=%b", it, c, valid_h[c], e_valid); end
                checks++; if (err_h[c] !== e_err) begin failures++; $display("FAIL rnd_err it=%0d c=%0d got=%b exp=%b", it, c, err_h[c], e_err); end
            end
            for (int k = 0; k < A; k++) begin
                checks++; if (seed_h[n][k*DW +: DW] !== w[k])
                    begin failures++; $display("FAIL rnd_seed it=%0d k=%0d got=%0h exp=%0h", it, k, seed_h[n][k*DW +: DW], w[k]); end
            end
        end
    endtask

    task automatic test_ignored();
        int nreq, ndone;
        logic [NW*DW-1:0] exp_seed;
        knobs_default();
        lat = 2; rerun_cyc = 2;
        spur_at[0] = 1'b1; spur_at[1] = 1'b1; spur_at[4] = 1'b1; spur_at[9] = 1'b1;
        for (int k = 0; k < NW; k++) begin
            exp_seed[k*DW +: DW] = {$urandom, $urandom};
            rsp_words.push_back(exp_seed[k*DW +: DW]);
        end
        sim_run(12);
        nreq = 0; ndone = 0;
        for (int c = 1; c <= 12; c++) begin nreq += int'(req_h[c]); ndone += int'(done_h[c]); end
        checks++; if (nreq != 2) begin failures++; $display("FAIL ign_req_count got=%0d exp=2", nreq); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
        checks++; if (done_h[7] !== 1'b1) begin failures++; $display("FAIL ign_done7 got=%b exp=1", done_h[7]); end
        checks++; if (seed_h[8] !== exp_seed) begin failures++; $display("FAIL ign_seed got=%0h exp=%0h", seed_h[8], exp_seed); end
        checks++; if (seed_h[12] !== exp_seed) begin failures++; $display("FAIL ign_seed_idle got=%0h exp=%0h", seed_h[12], exp_seed); end
    endtask

    task automatic test_clear();
        int ndone;
        knobs_default();
        lat = 2; clear_cyc = 5;
        rsp_words.push_back({$urandom, $urandom});
        rsp_words.push_back({$urandom, $urandom});
        sim_run(10);
        ndone = 0;
        for (int c = 1; c <= 10; c++) ndone += int'(done_h[c]);
        checks++; if (seed_h[5] === '0) begin failures++; $display("FAIL clr_word0_stored got=%0h exp=nonzero", seed_h[5]); end
        checks++; if (busy_h[6] !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy_h[6]); end
        checks++; if (seed_h[6] !== '0) begin failures++; $display("FAIL clr_seed got=%0h exp=0", seed_h[6]); end
        checks++; if (ndone != 0) begin failures++; $display("FAIL clr_done_count got=%0d exp=0", ndone); end
        checks++; if (seed_h[10] !== '0) begin failures++; $display("FAIL clr_seed_late got=%0h exp=0", seed_h[10]); end
        knobs_default();
        rsp_words.push_back({$urandom, $urandom});
        rsp_words.push_back({$urandom, $urandom});
        sim_run(7);
        checks++; if (done_h[5] !== 1'b1) begin failures++; $display("FAIL clr_rerun_done got=%b exp=1", done_h[5]); end
        checks++; if (valid_h[7] !== 1'b1) begin failures++; $display("FAIL clr_rerun_valid got=%b exp=1", valid_h[7]); end
    endtask

    task automatic test_async_reset();
        int ndone, nreq;
        knobs_default();
        lat = 2; rst_cyc = 2;
        rsp_words.push_back({$urandom, $urandom});
        rsp_words.push_back({$urandom, $urandom});
        sim_run(10);
        ndone = 0; nreq = 0;
        for (int c = 1; c <= 10; c++) begin ndone += int'(done_h[c]); nreq += int'(req_h[c]); end
        checks++; if (rst_zero_ok !== 1'b1) begin failures++; $display("FAIL arst_outputs_zero got=%b exp=1", rst_zero_ok); end
        checks++; if (ndone != 0) begin failures++; $display("FAIL arst_done_count got=%0d exp=0", ndone); end
        checks++; if (nreq != 1) begin failures++; $display("FAIL arst_req_count got=%0d exp=1", nreq); end
        knobs_default();
        lat = 2;
        rsp_words.push_back({$urandom, $urandom});
        rsp_words.push_back({$urandom, $urandom});
        sim_run(9);
        checks++; if (done_h[7] !== 1'b1) begin failures++; $display("FAIL arst_rerun_done got=%b exp=1", done_h[7]); end
        checks++; if (valid_h[8] !== 1'b1) begin failures++; $display("FAIL arst_rerun_valid got=%b exp=1", valid_h[8]); end
    endtask

    task automatic test_back_to_back();
        int nreq;
        logic [NW*DW-1:0] exp_seed;
        knobs_default();
        rerun_cyc = 6; resp_limit = 2 * NW;
        for (int k = 0; k < 2 * NW; k++) rsp_words.push_back({$urandom, $urandom});
        for (int k = 0; k < NW; k++) exp_seed[k*DW +: DW] = rsp_words[NW + k];
        sim_run(14);
        nreq = 0;
        for (int c = 1; c <= 14; c++) nreq += int'(req_h[c]);
        checks++; if (valid_h[6] !== 1'b1) begin failures++; $display("FAIL b2b_valid6 got=%b exp=1", valid_h[6]); end
        checks++; if (valid_h[7] !== 1'b0) begin failures++; $display("FAIL b2b_valid7 got=%b exp=0", valid_h[7]); end
        checks++; if (req_h[7] !== 1'b1) begin failures++; $display("FAIL b2b_req7 got=%b exp=1", req_h[7]); end
        checks++; if (nreq != 4) begin failures++; $display("FAIL b2b_req_count got=%0d exp=4", nreq); end
        checks++; if (done_h[11] !== 1'b1) begin failures++; $display("FAIL b2b_done11 got=%b exp=1", done_h[11]); end
        checks++; if (valid_h[12] !== 1'b1) begin failures++; $display("FAIL b2b_valid12 got=%b exp=1", valid_h[12]); end
        checks++; if (seed_h[14] !== exp_seed) begin failures++; $display("FAIL b2b_seed got=%0h exp=%0h", seed_h[14], exp_seed); end
        // clear and run together in IDLE: run must be dropped
        knobs_default();
        clear_cyc = 0;
        sim_run(6);
        nreq = 0;
        for (int c = 1; c <= 6; c++) nreq += int'(req_h[c]);
        checks++; if (nreq != 0) begin failures++; $display("FAIL coinc_req_count got=%0d exp=0", nreq); end
        checks++; if (busy_h[1] !== 1'b0) begin failures++; $display("FAIL coinc_busy got=%b exp=0", busy_h[1]); end
        checks++; if (valid_h[1] !== 1'b0) begin failures++; $display("FAIL coinc_valid got=%b exp=0", valid_h[1]); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_random();
        test_ignored();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
